// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, control-FSM states and shift-amount sizing.
package alu_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpAnd = 3'd2,
        OpOr  = 3'd3,
        OpXor = 3'd4,
        OpShl = 3'd5,
        OpShr = 3'd6,
        OpMul = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } alu_state_e;

    localparam int unsigned DefaultWidth  = 16;
    localparam int unsigned DefaultShamtW = $clog2(DefaultWidth);

    // Width of the shift-amount field taken from the low bits of operand B.
    function automatic int unsigned shamt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per clock, WIDTH iterations in total.
// The first iteration is folded into the start edge, so the count reaches WIDTH WIDTH edges later.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_start,
    input  logic [WIDTH-1:0]             i_a,
    input  logic [WIDTH-1:0]             i_b,
    output logic                         o_done,
    output logic [2*WIDTH-1:0]           o_product,
    output logic [$clog2(WIDTH+1)-1:0]   o_count
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (i_start) begin
            acc_d    = i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, i_a, 1'b0};
            mplier_d = i_b >> 1;
            cnt_d    = CntW'(1);
        end else if (cnt_q != '0 && cnt_q != CntLast) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_done    = (cnt_q == CntLast);
    assign o_product = acc_q;
    assign o_count   = cnt_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and registered N/Z/C/V flags.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier behind opcode 7.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op_sel,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_alu_out,
    output logic             o_n,
    output logic             o_z,
    output logic             o_c,
    output logic             o_v
);
    localparam int unsigned ShW = shamt_width(WIDTH);

    alu_state_e       state_q, state_d;
    alu_op_e          op;
    logic [ShW-1:0]   sh_amt;
    logic [WIDTH-1:0] alu_res, cap_res, res_q, res_d;
    logic             alu_c, alu_v, cap_c, cap_v, cap, accept, go_busy;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    assign op      = alu_op_e'(i_op_sel);
    assign sh_amt  = i_op_b[ShW-1:0];
    assign o_ready = (state_q == StIdle) || (state_q == StDone && i_ready);
    assign accept  = i_valid && o_ready;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OpAdd: begin
                {alu_c, alu_res} = {1'b0, i_op_a} + {1'b0, i_op_b};
                alu_v = (i_op_a[WIDTH-1] == i_op_b[WIDTH-1])
                     && (alu_res[WIDTH-1] != i_op_a[WIDTH-1]);
            end
            OpSub: begin
                {alu_c, alu_res} = {1'b0, i_op_a} - {1'b0, i_op_b};
                alu_v = (i_op_a[WIDTH-1] != i_op_b[WIDTH-1])
                     && (alu_res[WIDTH-1] != i_op_a[WIDTH-1]);
            end
            OpAnd: alu_res = i_op_a & i_op_b;
            OpOr:  alu_res = i_op_a | i_op_b;
            OpXor: alu_res = i_op_a ^ i_op_b;
            // The extra bit beside the operand catches the last bit shifted out.
            OpShl: {alu_c, alu_res} = {1'b0, i_op_a} << sh_amt;
            OpShr: {alu_res, alu_c} = {i_op_a, 1'b0} >> sh_amt;
            OpMul: ;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic                 mul_done, mul_fin, mul_hi_nz;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [CntW-1:0]      mul_cnt;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (accept && go_busy),
        .i_a       (i_op_a),
        .i_b       (i_op_b),
        .o_done    (mul_done),
        .o_product (mul_prod),
        .o_count   (mul_cnt)
    );

    assign go_busy   = (op == OpMul);
    assign mul_fin   = mul_done && (mul_cnt == CntW'(WIDTH));
    assign mul_hi_nz = |mul_prod[2*WIDTH-1:WIDTH];
`else
    assign go_busy = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        cap_res = alu_res;
        cap_c   = alu_c;
        cap_v   = alu_v;
        unique case (state_q)
            StIdle: ;
            StBusy: begin
`ifdef ALU_MUL_EN
                if (mul_fin) begin
                    state_d = StDone;
                    cap     = 1'b1;
                    cap_res = mul_prod[WIDTH-1:0];
                    cap_c   = mul_hi_nz;
                    cap_v   = mul_hi_nz;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                if (i_ready && !i_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            if (go_busy) begin
                state_d = StBusy;
            end else begin
                state_d = StDone;
                cap     = 1'b1;
            end
        end
    end

    // Result and flags only change together, when a finished result is captured.
    assign res_d = cap ? cap_res : res_q;
    assign n_d   = cap ? cap_res[WIDTH-1] : n_q;
    assign z_d   = cap ? (cap_res == '0) : z_q;
    assign c_d   = cap ? cap_c : c_q;
    assign v_d   = cap ? cap_v : v_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            res_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign o_valid   = (state_q == StDone);
    assign o_alu_out = res_q;
    assign o_n       = n_q;
    assign o_z       = z_q;
    assign o_c       = c_q;
    assign o_v       = v_q;

endmodule
